// File: rtl/pet_pkg.sv
// pet_pkg: shared face codes, FSM states and level limits for the pet mood tracker.
package pet_pkg;
  localparam int LVL_W = 4;
  localparam int LVL_MAX = 15;
  localparam int AW = LVL_W + 2;
  typedef enum logic [1:0] {
    FACE_HAPPY = 2'b00,
    FACE_SAD   = 2'b01,
    FACE_ANGRY = 2'b10,
    FACE_SLEEP = 2'b11
  } face_t;
  typedef enum logic {AWAKE = 1'b0, SLEEP = 1'b1} state_t;
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic signed [AW-1:0] v);
    return v < 0 ? '0 : v > LVL_MAX ? LVL_W'(LVL_MAX) : v[LVL_W-1:0];
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: button rising-edge pulse; sync + debounce when PET_BTN_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  if (DEBOUNCE_CYC < 1) begin : g_cfg_check
    $error("DEBOUNCE_CYC must be at least 1");
  end
`ifdef PET_BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2, level, level_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      level_q <= level;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign press = level & ~level_q;
`else
  logic btn_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) btn_q <= 1'b0;
    else btn_q <= btn;
  assign press = btn & ~btn_q;
`endif
endmodule

// File: rtl/pet_mood_fsm.sv
// pet_mood_fsm: food/joy/sleep tracker producing the 2-bit face code and a face-change strobe.
// Optional button debounce is enabled with PET_BTN_DEBOUNCE_EN.
module pet_mood_fsm
  import pet_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int DECAY_TICKS  = 10,
  parameter int SLEEP_TICKS  = 30,
  parameter int FEED_STEP    = 4,
  parameter int PLAY_STEP    = 3,
  parameter int SAD_THR      = 5,
  parameter int ANGRY_THR    = 3,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_feed,
  input  logic             btn_play,
  input  logic             btn_sleep,
  output logic [1:0]       face,
  output logic             face_upd,
  output logic [LVL_W-1:0] food,
  output logic [LVL_W-1:0] joy,
  output logic             asleep
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = DECAY_TICKS > 1 ? $clog2(DECAY_TICKS) : 1;
  localparam int SW = SLEEP_TICKS > 1 ? $clog2(SLEEP_TICKS) : 1;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] decay_cnt;
  logic [SW-1:0] sleep_cnt;
  logic [LVL_W-1:0] food_r, joy_r;
  state_t state;
  face_t face_r, face_nxt;
  logic tick, feed_p, play_p, sleep_p, decay_wrap, wake_auto;
  logic signed [AW-1:0] food_sum, joy_sum;
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_feed (.clk(clk), .reset(reset), .btn(btn_feed), .press(feed_p));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_play (.clk(clk), .reset(reset), .btn(btn_play), .press(play_p));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sleep (.clk(clk), .reset(reset), .btn(btn_sleep), .press(sleep_p));
  always_comb begin
    tick = pre_cnt == PW'(TICK_DIV - 1);
    decay_wrap = tick && decay_cnt == DW'(DECAY_TICKS - 1);
    wake_auto = tick && sleep_cnt == SW'(SLEEP_TICKS - 1);
    // all simultaneous deltas are summed before a single clamp
    food_sum = AW'(food_r) - AW'(decay_wrap) + (feed_p ? AW'(FEED_STEP) : AW'(0)) - AW'(play_p);
    joy_sum = AW'(joy_r) - AW'(decay_wrap) + (play_p ? AW'(PLAY_STEP) : AW'(0));
    face_nxt = state == SLEEP ? FACE_SLEEP :
               food_r <= LVL_W'(ANGRY_THR) ? FACE_ANGRY :
               joy_r <= LVL_W'(SAD_THR) ? FACE_SAD : FACE_HAPPY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_cnt <= '0;
      decay_cnt <= '0;
      sleep_cnt <= '0;
      state <= AWAKE;
      asleep <= 1'b0;
      food_r <= LVL_W'(LVL_MAX);
      joy_r <= LVL_W'(LVL_MAX);
      face_r <= FACE_HAPPY;
      face_upd <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      face_r <= face_nxt;
      face_upd <= face_nxt != face_r;
      if (state == AWAKE) begin
        if (tick) decay_cnt <= decay_wrap ? '0 : decay_cnt + 1'b1;
        if (sleep_p) begin
          state <= SLEEP;
          asleep <= 1'b1;
          sleep_cnt <= '0;
        end else begin
          food_r <= clamp_lvl(food_sum);
          joy_r <= clamp_lvl(joy_sum);
        end
      end else begin
        if (tick) sleep_cnt <= sleep_cnt + 1'b1;
        if (sleep_p || wake_auto) begin
          state <= AWAKE;
          asleep <= 1'b0;
        end
        if (!sleep_p && wake_auto) joy_r <= clamp_lvl(AW'(joy_r) + AW'(2));
      end
    end
  assign face = face_r;
  assign food = food_r;
  assign joy = joy_r;
endmodule

// File: tb/tb_pet_mood_fsm.sv
// tb_pet_mood_fsm: directed scenarios; face changes are checked by a scoreboard monitor on face_upd.
module tb_pet_mood_fsm;
  logic clk = 1'b0, reset = 1'b1, btn_feed = 1'b0, btn_play = 1'b0, btn_sleep = 1'b0;
  logic [1:0] face;
  logic face_upd, asleep;
  logic [3:0] food, joy;
  int cyc, n_checks = 0, n_errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  pet_mood_fsm #(
    .TICK_DIV(4), .DECAY_TICKS(2), .SLEEP_TICKS(3), .FEED_STEP(4),
    .PLAY_STEP(3), .SAD_THR(5), .ANGRY_THR(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_feed(btn_feed), .btn_play(btn_play), .btn_sleep(btn_sleep),
    .face(face), .face_upd(face_upd), .food(food), .joy(joy), .asleep(asleep)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic at_edge(input int n);
    int g = 0;
    while (cyc < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) check("edge_timeout", cyc, n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_face"}, face, 0);
    check({tag, "_face_upd"}, face_upd, 0);
    check({tag, "_food"}, food, 15);
    check({tag, "_joy"}, joy, 15);
    check({tag, "_asleep"}, asleep, 0);
  endtask

  // scoreboard monitor: every face_upd pulse consumes one expected face
  always @(negedge clk)
    if (face_upd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_face_upd at edge %0d: face=%0d, no change expected", cyc, face);
      end else check("scoreboard_face", face, exp_q.pop_front());
    end

  initial begin
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    // idle decay: sad after 10 decays, angry after 12
    exp_q.push_back(1);
    exp_q.push_back(2);
    at_edge(7);  check("food_before_first_decay", food, 15);
    at_edge(8);  check("food_decay1", food, 14); check("joy_decay1", joy, 14);
    at_edge(80); check("food_decay10", food, 5); check("joy_decay10", joy, 5); check("face_pre_sad", face, 0);
    at_edge(81); check("face_sad", face, 1);
    at_edge(96); check("food_decay12", food, 3); check("joy_decay12", joy, 3);
    at_edge(97); check("face_angry", face, 2);
    btn_feed = 1'b1;
    exp_q.push_back(1);
    at_edge(98); check("food_after_feed", food, 7);
    btn_feed = 1'b0;
    at_edge(99); check("face_sad_after_feed", face, 1);
    at_edge(104); check("food_pre_reset", food, 6); check("joy_pre_reset", joy, 2);
    at_edge(106);
    check("pending_before_reset", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    check("face_upd_in_reset", face_upd, 0);
    reset = 1'b0;
    // second run: simultaneous events, sleep handling
    at_edge(7);  check("b_food_before_first_decay", food, 15);
    at_edge(8);  check("b_food_decay1", food, 14); check("b_joy_decay1", joy, 14);
    at_edge(15); btn_feed = 1'b1; btn_play = 1'b1;
    at_edge(16); check("combo_food", food, 15); check("combo_joy", joy, 15);
    btn_feed = 1'b0; btn_play = 1'b0;
    at_edge(17); btn_play = 1'b1;
    at_edge(18); check("play_food", food, 14); check("play_joy", joy, 15);
    btn_play = 1'b0;
    at_edge(20); btn_sleep = 1'b1; exp_q.push_back(3);
    at_edge(21); check("asleep_enter", asleep, 1);
    btn_sleep = 1'b0;
    at_edge(22); check("face_sleep", face, 3);
    at_edge(23); btn_feed = 1'b1;
    at_edge(24); check("feed_in_sleep_food", food, 14); check("still_asleep", asleep, 1);
    btn_feed = 1'b0;
    at_edge(31); check("asleep_before_wake", asleep, 1); check("joy_before_wake", joy, 15);
    exp_q.push_back(0);
    at_edge(32); check("auto_wake_asleep", asleep, 0); check("auto_wake_joy_sat", joy, 15);
    at_edge(33); check("face_after_wake", face, 0);
    at_edge(35); check("food_decay_held", food, 14);
    at_edge(36); check("food_decay_resume", food, 13); check("joy_decay_resume", joy, 14);
    at_edge(37); btn_sleep = 1'b1; exp_q.push_back(3);
    at_edge(38); check("asleep_second", asleep, 1);
    btn_sleep = 1'b0;
    at_edge(39); btn_sleep = 1'b1; exp_q.push_back(0);
    at_edge(40); check("manual_wake_asleep", asleep, 0); check("manual_wake_joy", joy, 14);
    btn_sleep = 1'b0;
    at_edge(48); check("food_decay_b", food, 12); check("joy_decay_b", joy, 13);
    at_edge(56); check("food_decay_c", food, 11); check("joy_decay_c", joy, 12);
    at_edge(57); btn_sleep = 1'b1; btn_feed = 1'b1; exp_q.push_back(3);
    at_edge(58); check("sleep_feed_asleep", asleep, 1); check("sleep_feed_food", food, 11);
    btn_sleep = 1'b0; btn_feed = 1'b0;
    at_edge(59); check("face_sleep_third", face, 3);
    at_edge(67); check("joy_before_wake2", joy, 12);
    exp_q.push_back(0);
    at_edge(68); check("auto_wake2_asleep", asleep, 0); check("auto_wake2_joy", joy, 14); check("auto_wake2_food", food, 11);
    at_edge(69); check("face_after_wake2", face, 0);
    at_edge(75); check("pending_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
